// File: rtl/sram_like_slave.sv
// Responder end of the sram-like bus, fronting a synchronous single-port RAM
// with one cycle of read latency. Up to MAX_OUTST transactions may be accepted
// ahead of their responses; responses come back strictly in acceptance order.
// An LFSR can gate addr_ok and data_ok to shake out master handshake bugs.
//
// Handshake: req is the request valid and addr_ok its ready; a request
// transfers in any cycle where both are high (hs). data_ok is a one-cycle
// response valid with no ready: the master must take rdata in that cycle.
module sram_like_slave #(
  parameter int          ADDR_W    = 16,
  parameter int          MAX_OUTST = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  input  logic              delay_en,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int             CNT_W    = $clog2(MAX_OUTST + 1);
  localparam int             PTR_W    = $clog2(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

  logic [15:0]      lfsr;
  logic             acc_gate;
  logic             rsp_gate;
  logic             hs;
  logic             pop;
  logic             push;
  logic [31:0]      push_data;
  logic [CNT_W-1:0] cnt;
  logic             pend_valid;
  logic             pend_wr;
  logic [31:0]      fifo_mem [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_nonempty;

  // size and the byte offset do not affect the access: wstrb alone selects bytes.
  logic unused_bits;
  assign unused_bits = ^{size, addr[1:0], addr[31:ADDR_W+2]};

  // Stall LFSR, taps 16,14,13,11 in right-shift Fibonacci form.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Bus handshakes, RAM request and response muxing; everything forced quiet in reset.
  always_comb begin
    acc_gate      = ~(delay_en & (lfsr[1:0] == 2'b00));
    rsp_gate      = ~(delay_en & (lfsr[3:2] == 2'b00));
    fifo_nonempty = (fifo_cnt != '0);
    // cnt is the registered value, so a pop this cycle frees no slot until next cycle.
    addr_ok       = resetn & req & acc_gate & (cnt < CNT_MAX);
    hs            = req & addr_ok;
    data_ok       = resetn & fifo_nonempty & rsp_gate;
    pop           = data_ok;
    rdata         = (resetn & fifo_nonempty) ? fifo_mem[rd_ptr] : 32'h0;
    ram_en        = hs;
    ram_we        = (hs & wr) ? wstrb : 4'b0000;
    ram_addr      = addr[ADDR_W+1:2];
    ram_wdata     = wdata;
    push          = pend_valid;
    push_data     = pend_wr ? 32'h0 : ram_rdata;
  end

  // Pending stage: remembers the RAM access issued last cycle until its data returns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
    end else begin
      pend_valid <= hs;
      pend_wr    <= wr;
    end
  end

  // Response FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  // FIFO pointers/occupancy and the outstanding counter (pending stage + FIFO).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cnt      <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({hs, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed and random bench for sram_like_slave with a RAM model, an LFSR
// reference, and an in-order response scoreboard.
module tb_sram_like_slave;

  localparam int          ADDR_W    = 16;
  localparam int          MAX_OUTST = 4;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;
  logic              delay_en;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int outst    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rsp_q[$];
  int          hs_cyc_q[$];
  int          dok_cyc_q[$];
  logic [31:0] mem [int];
  logic [31:0] ref_mem [int];
  logic [15:0] lfsr_m;

  sram_like_slave #(.ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST), .LFSR_SEED(SEED)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .delay_en(delay_en), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // ---------------- clock / reset-related models ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clk) lfsr_m <= !resetn ? SEED : lfsr_step(lfsr_m);

  function automatic logic [31:0] init_word(input int i);
    return (i == 'h10) ? 32'h12345678 : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Synchronous RAM with one cycle read latency.
  always @(posedge clk) begin
    int i;
    logic [31:0] cur;
    if (ram_en) begin
      i   = int'(ram_addr);
      cur = mem.exists(i) ? mem[i] : init_word(i);
      if (ram_we == 4'b0000) ram_rdata <= cur;
      else                   mem[i] = merge(cur, ram_wdata, ram_we);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: expected data pushed at each handshake, popped at each data_ok.
  always @(negedge clk) begin
    logic        exp_ok;
    logic        rsp_open;
    int          idx;
    logic [31:0] cur;
    if (resetn === 1'b1) begin
      exp_ok   = req & (~delay_en | (lfsr_m[1:0] != 2'b00)) & (outst < MAX_OUTST);
      rsp_open = ~delay_en | (lfsr_m[3:2] != 2'b00);
      check("addr_ok", 32'(addr_ok), 32'(exp_ok));
      if (outst == 0) check("idle_rdata", rdata, 32'h0);
      if (data_ok) begin
        check("dok_gate", 32'(rsp_open), 32'h1);
        if (exp_q.size() == 0) check("dok_spurious", 32'(data_ok), 32'h0);
        else                   check("rdata", rdata, exp_q.pop_front());
        rsp_q.push_back(rdata);
        dok_cyc_q.push_back(cyc);
        outst = outst - 1;
      end
      if (req && addr_ok) begin
        idx = int'(addr[ADDR_W+1:2]);
        cur = ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
        if (wr) begin
          ref_mem[idx] = merge(cur, wdata, wstrb);
          exp_q.push_back(32'h0);
        end else begin
          exp_q.push_back(cur);
        end
        check("hs_ram_en", 32'(ram_en), 32'h1);
        check("hs_ram_addr", 32'(ram_addr), 32'(idx));
        check("hs_ram_we", 32'(ram_we), wr ? 32'(wstrb) : 32'h0);
        check("hs_ram_wdata", ram_wdata, wdata);
        hs_cyc_q.push_back(cyc);
        outst = outst + 1;
      end else begin
        check("idle_ram_en", 32'(ram_en), 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
    int n;
    n = 0;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    size = 2'($urandom_range(0, 3));
    @(negedge clk);
    while (!addr_ok && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!addr_ok) check("hs_timeout", 32'(addr_ok), 32'h1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      n++;
      @(posedge clk);
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic clear_logs();
    rsp_q.delete();
    hs_cyc_q.delete();
    dok_cyc_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] l2, l3;
    logic        found;
    int          h0, n;

    resetn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2; wstrb = 4'h0;
    addr = 32'h0; wdata = 32'h0; delay_en = 1'b0;

    // Reset: outputs quiet even with req asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr_ok", 32'(addr_ok), 32'h0);
    check("rst_data_ok", 32'(data_ok), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1; req = 1'b0;
    idle(2);

    // Single read: two-cycle latency, word 0x10.
    clear_logs();
    do_req(1'b0, 32'h40, 4'h0, 32'h0);
    idle(3);
    check("t1_dok_count", 32'(dok_cyc_q.size()), 32'd1);
    if (dok_cyc_q.size() == 1 && hs_cyc_q.size() == 1) begin
      check("t1_latency", 32'(dok_cyc_q[0] - hs_cyc_q[0]), 32'd2);
      check("t1_rdata", rsp_q[0], 32'h12345678);
    end

    // Byte write then read of the same word.
    clear_logs();
    do_req(1'b1, 32'h41, 4'b0010, 32'h0000AB00);
    do_req(1'b0, 32'h40, 4'h0, 32'h0);
    idle(4);
    check("t2_dok_count", 32'(rsp_q.size()), 32'd2);
    if (rsp_q.size() == 2) begin
      check("t2_wr_rdata", rsp_q[0], 32'h0);
      check("t2_rd_rdata", rsp_q[1], 32'h1234AB78);
    end

    // Back-to-back reads: one per cycle in both directions.
    clear_logs();
    for (int i = 0; i < 8; i++) do_req(1'b0, 32'(i * 4), 4'h0, 32'h0);
    idle(10);
    check("t3_hs_count", 32'(hs_cyc_q.size()), 32'd8);
    check("t3_dok_count", 32'(dok_cyc_q.size()), 32'd8);
    if (hs_cyc_q.size() == 8 && dok_cyc_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check("t3_hs_cyc", 32'(hs_cyc_q[k]), 32'(hs_cyc_q[0] + k));
        check("t3_dok_cyc", 32'(dok_cyc_q[k]), 32'(hs_cyc_q[0] + 2 + k));
      end
    end

    // Outstanding limit: find a window where responses stall but accepts don't.
    clear_logs();
    found = 1'b0;
    n = 0;
    while (!found && n < 5000) begin
      l2 = lfsr_step(lfsr_step(lfsr_m));
      l3 = lfsr_step(l2);
      if (l2[1:0] != 2'b00 && l2[3:2] == 2'b00 && l3[1:0] != 2'b00 && l3[3:2] == 2'b00)
        found = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    check("t4_window_found", 32'(found), 32'h1);
    delay_en = 1'b0;
    do_req(1'b0, 32'h100, 4'h0, 32'h0);
    do_req(1'b0, 32'h104, 4'h0, 32'h0);
    delay_en = 1'b1;
    do_req(1'b0, 32'h108, 4'h0, 32'h0);
    do_req(1'b0, 32'h10C, 4'h0, 32'h0);
    delay_en = 1'b0;
    req = 1'b1; wr = 1'b0; addr = 32'h110;
    @(negedge clk);
    check("t4_limit_block", 32'(addr_ok), 32'h0);
    do_req(1'b0, 32'h110, 4'h0, 32'h0);
    do_req(1'b0, 32'h114, 4'h0, 32'h0);
    drain();
    check("t4_hs_count", 32'(hs_cyc_q.size()), 32'd6);
    check("t4_dok_count", 32'(dok_cyc_q.size()), 32'd6);
    if (hs_cyc_q.size() == 6 && dok_cyc_q.size() == 6) begin
      h0 = hs_cyc_q[0];
      check("t4_hs3_cyc", 32'(hs_cyc_q[3]), 32'(h0 + 3));
      check("t4_first_dok", 32'(dok_cyc_q[0]), 32'(h0 + 4));
      check("t4_resume", 32'(hs_cyc_q[4]), 32'(dok_cyc_q[0] + 1));
    end

    // Random mixed traffic with stalls.
    clear_logs();
    delay_en = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      if ($urandom_range(0, 9) == 0) delay_en = ~delay_en;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      do_req(1'($urandom_range(0, 1)),
             (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), $urandom);
    end
    drain();
    check("t5_pairs", 32'(dok_cyc_q.size()), 32'(hs_cyc_q.size()));
    check("t5_count", 32'(hs_cyc_q.size()), 32'd1000);

    // Reset in the middle of traffic drops everything in flight.
    delay_en = 1'b0;
    idle(2);
    do_req(1'b0, 32'h40, 4'h0, 32'h0);
    do_req(1'b0, 32'h44, 4'h0, 32'h0);
    do_req(1'b0, 32'h48, 4'h0, 32'h0);
    req = 1'b1; addr = 32'h4C;
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_data_ok", 32'(data_ok), 32'h0);
    check("mid_rst_addr_ok", 32'(addr_ok), 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_ram_en", 32'(ram_en), 32'h0);
    exp_q.delete();
    outst = 0;
    clear_logs();
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(4);
    check("post_rst_stale", 32'(dok_cyc_q.size()), 32'd0);
    do_req(1'b0, 32'h40, 4'h0, 32'h0);
    idle(3);
    check("post_rst_dok", 32'(dok_cyc_q.size()), 32'd1);
    if (dok_cyc_q.size() == 1 && hs_cyc_q.size() == 1) begin
      check("post_rst_latency", 32'(dok_cyc_q[0] - hs_cyc_q[0]), 32'd2);
      check("post_rst_rdata", rsp_q[0], ref_mem.exists('h10) ? ref_mem['h10] : init_word('h10));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
